sccb_responder: RTL
===================

Name: sccb_responder

Overview:
- SCCB slave (responder) that emulates the camera side of the three-wire SCCB bus driven by the OV7670 camera driver.
- Oversamples SIO_C/SIO_D on the system clock and decodes 3-phase writes and 2-phase address-set + 2-phase reads.
- Holds a 256x8 register bank and drives SIO_D low through an open-drain enable during read data.
- Used as the bus-functional camera model in simulation and for board-level loopback of the driver.

Parameters:
- DEVICE_ID, 8'h42, 8-bit write ID; the read ID is DEVICE_ID | 8'h01.
- SYNC_STAGES, 2, number of synchronizer flops on sio_c and sio_d (minimum 2).

Ports:
- clk  input  1  system clock; must be at least 8x the SCL frequency.
- reset_  input  1  asynchronous, active-low reset.
- sio_c  input  1  SCCB clock from the master.
- sio_d_in  input  1  SCCB data as seen on the pad.
- sio_d_oe  output  1  1 = pull SIO_D low (pad: oe ? 1'b0 : 1'bZ).
- wr_valid  output  1  one-cycle pulse when a register write commits.
- wr_addr  output  8  sub-address of the committed write; valid with wr_valid.
- wr_data  output  8  data of the committed write; valid with wr_valid.
- busy  output  1  high from START detect until STOP or return to IDLE.
- proto_err  output  1  sticky; set on wrong ID, extra write byte, or STOP mid-byte; cleared at the next START.
- dbg_addr  input  8  debug read address into the register bank.
- dbg_data  output  8  bank[dbg_addr], registered, 1-cycle latency.

Behaviour:
- Reset (reset_=0, async): all bank entries 8'h00, pointer 8'h00, state IDLE, all outputs 0.
- Sync and edge detect:
  - sio_c and sio_d pass through SYNC_STAGES flops; edges are detected on the synchronized copies.
  - START = sda falls while scl is high; STOP = sda rises while scl is high.
  - START/STOP take priority over bit processing in the same cycle.
- Bit timing:
  - Bits are sampled on the synchronized scl rising edge.
  - sio_d_oe changes only on the synchronized scl falling edge, within 1 clk of detecting it.
  - Bits are MSB first; a bit counter counts 7 down to 0.
- States:
  - IDLE.
  - ID: shift 8 bits.
  - ID_X: 9th bit.
    - ID == DEVICE_ID → SUB.
    - ID == read ID → RD.
    - Otherwise → IGNORE and set proto_err.
  - SUB: shift 8 bits into the pointer → SUB_X → WR.
  - WR: shift 8 bits → WR_X.
    - At the end of WR_X, write bank[pointer] and pulse wr_valid → DONE.
  - DONE: any further byte sets proto_err and leads to IGNORE.
  - RD: on each scl fall, sio_d_oe = ~bank[pointer][bit]. After 8 bits → RD_NA: sio_d_oe = 0 and the master NA bit is ignored → DONE.
  - IGNORE: sio_d_oe = 0 until START or STOP.
- START from any state (including repeated START): bit counter = 7, state → ID, busy = 1, proto_err cleared.
- STOP from any state: state → IDLE, sio_d_oe = 0 within 1 clk, busy = 0.
  - STOP before WR_X completes: no write; proto_err is set if it occurs mid-byte.
- Pointer:
  - Persists across transactions.
  - A 2-phase write (ID + SUB + STOP) sets the pointer for a following 2-phase read.
  - No auto-increment.
- Write and debug read to the same address in one cycle: dbg_data shows the old value, then the new value the next cycle.
- sio_d_oe is never asserted while scl is high except when it holds a bit level already set on the preceding scl fall.

Optional Feature:
- Macro: SCCB_RESP_ACK_DRIVE_EN.
- Defined: in ID_X (matching ID), SUB_X and WR_X, sio_d_oe = 1 from the falling edge that starts the 9th bit until the following falling edge, mimicking OV7670 ACK.
- Undefined: the 9th "don't care" bit is released (sio_d_oe = 0), per the SCCB spec.
- Decode and all other timing are identical in both builds.

Test Plan:
- Write: START, 0x42, 0x12, 0x80, STOP → one wr_valid pulse with wr_addr=0x12, wr_data=0x80; dbg_addr=0x12 gives dbg_data=0x80; busy falls within SYNC_STAGES+2 clk of STOP.
- Read-back: START, 0x42, 0x0A, STOP; then START, 0x43, 8 read clocks, NA, STOP → master samples 0x80 after bank[0x0A] was preloaded to 0x80 by a write; sio_d_oe is 0 after STOP; no wr_valid.
- Wrong ID: START, 0x60, 0x12, 0x55, STOP → no wr_valid, sio_d_oe stays 0, proto_err=1; next START clears it.
- Aborted write: START, 0x42, 0x20, 4 data bits, STOP → no wr_valid, bank[0x20] unchanged, proto_err=1, state IDLE.
- Repeated START: START, 0x42, 0x30, repeated START, 0x43, read → reads bank[0x30]. Then reset_ low mid-read → sio_d_oe=0 immediately, bank[0x30] reads 0x00.
- ACK build: with SCCB_RESP_ACK_DRIVE_EN defined, the first test shows sio_d_oe=1 during each of the three 9th bits. Without the macro, sio_d_oe stays 0 for the whole write.

Source files
------------

// File: rtl/sccb_responder.sv
// sccb_responder
//   Camera-side SCCB responder. This is the bus-functional model of an
//   OV7670 register interface. It oversamples SIO_C/SIO_D on clk, which must
//   run at least 8x the SCL rate. It decodes 3-phase writes and 2-phase
//   address-set followed by 2-phase reads. It holds a 256x8 register bank and
//   answers reads by pulling SIO_D low through an open-drain enable.
//
//   Build option: `define SCCB_RESP_ACK_DRIVE_EN drives the 9th bit low after
//   a matching ID, after the sub-address and after write data, the way a real
//   OV7670 does. When it is undefined, the 9th bit is released.
//
// Ports
//   clk        system clock
//   reset_     asynchronous active-low reset
//   sio_c      SCCB clock from the master
//   sio_d_in   SCCB data as seen on the pad
//   sio_d_oe   1 = pull SIO_D low (pad: oe ? 1'b0 : 1'bZ)
//   wr_valid   one-cycle pulse when a register write commits
//   wr_addr    sub-address of the committed write
//   wr_data    data of the committed write
//   busy       high between START and STOP
//   proto_err  sticky error flag; cleared by the next START
//   dbg_addr   debug read address into the register bank
//   dbg_data   bank[dbg_addr], registered, 1-cycle latency
//
// FSM states
//   state  | meaning
//   IDLE   | bus free, waiting for START
//   ID     | shifting the 8-bit device ID
//   ID_X   | 9th bit after the ID; decode write/read/foreign ID
//   SUB    | shifting the sub-address (pointer)
//   SUB_X  | 9th bit after the sub-address
//   WR     | shifting write data
//   WR_X   | 9th bit after data; commits the write
//   DONE   | transaction complete; a further full byte is an error
//   RD     | driving bank[pointer] MSB first
//   RD_NA  | master NA bit, SIO_D released
//   IGNORE | foreign or bad transaction; stay off the bus until START/STOP
module sccb_responder #(
  parameter logic [7:0]  DEVICE_ID   = 8'h42,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_,
  input  logic       sio_c,
  input  logic       sio_d_in,
  output logic       sio_d_oe,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic       proto_err,
  input  logic [7:0] dbg_addr,
  output logic [7:0] dbg_data
);

  localparam logic [7:0] READ_ID = DEVICE_ID | 8'h01;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_ID     = 4'd1;
  localparam logic [3:0] S_ID_X   = 4'd2;
  localparam logic [3:0] S_SUB    = 4'd3;
  localparam logic [3:0] S_SUB_X  = 4'd4;
  localparam logic [3:0] S_WR     = 4'd5;
  localparam logic [3:0] S_WR_X   = 4'd6;
  localparam logic [3:0] S_DONE   = 4'd7;
  localparam logic [3:0] S_RD     = 4'd8;
  localparam logic [3:0] S_RD_NA  = 4'd9;
  localparam logic [3:0] S_IGNORE = 4'd10;

  // Synchronizers and edge detection
  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;
  logic                   scl;
  logic                   sda;
  logic                   scl_rise;
  logic                   scl_fall;
  logic                   start_det;
  logic                   stop_det;

  // The synchronizers reset to the idle-bus level so that releasing reset
  // on an idle bus does not produce a spurious edge.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], sio_c};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sio_d_in};
      scl_prev_q <= scl;
      sda_prev_q <= sda;
    end
  end

  assign scl       = scl_sync_q[SYNC_STAGES-1];
  assign sda       = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl & ~scl_prev_q;
  assign scl_fall  = ~scl & scl_prev_q;
  assign start_det = scl & scl_prev_q & sda_prev_q & ~sda;
  assign stop_det  = scl & scl_prev_q & ~sda_prev_q & sda;

  logic ack_drive;
`ifdef SCCB_RESP_ACK_DRIVE_EN
  assign ack_drive = 1'b1;
`else
  assign ack_drive = 1'b0;
`endif

  // Protocol FSM
  logic [3:0] state_q, state_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] ptr_q, ptr_d;
  logic       oe_q, oe_d;
  logic       busy_q, busy_d;
  logic       err_q, err_d;
  logic       wr_en;
  logic       mid_byte;
  logic [7:0] bank_q [256];
  logic [7:0] dbg_data_q;
  logic       wr_valid_q;
  logic [7:0] wr_addr_q;
  logic [7:0] wr_data_q;

  // Every STOP (or repeated START) is preceded by one SCL rise that is not a
  // data bit. So a byte counts as interrupted only after two or more rises.
  assign mid_byte = ((state_q == S_ID) || (state_q == S_SUB) ||
                     (state_q == S_WR) || (state_q == S_DONE)) &&
                    (bitcnt_q <= 3'd5);

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    ptr_d    = ptr_q;
    oe_d     = oe_q;
    busy_d   = busy_q;
    err_d    = err_q;
    wr_en    = 1'b0;
    if (start_det) begin
      state_d  = S_ID;
      bitcnt_d = 3'd7;
      busy_d   = 1'b1;
      err_d    = 1'b0;
      oe_d     = 1'b0;
    end else if (stop_det) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      oe_d    = 1'b0;
      if (mid_byte) err_d = 1'b1;
    end else if (scl_rise) begin
      case (state_q)
        S_ID, S_SUB, S_WR: begin
          shift_d = {shift_q[6:0], sda};
          if (bitcnt_q == 3'd0) begin
            bitcnt_d = 3'd7;
            if (state_q == S_ID) begin
              state_d = S_ID_X;
            end else if (state_q == S_SUB) begin
              state_d = S_SUB_X;
              ptr_d   = {shift_q[6:0], sda};
            end else begin
              state_d = S_WR_X;
            end
          end else begin
            bitcnt_d = bitcnt_q - 3'd1;
          end
        end
        S_ID_X: begin
          bitcnt_d = 3'd7;
          if (shift_q == DEVICE_ID) begin
            state_d = S_SUB;
          end else if (shift_q == READ_ID) begin
            state_d = S_RD;
          end else begin
            state_d = S_IGNORE;
            err_d   = 1'b1;
          end
        end
        S_SUB_X: begin
          state_d  = S_WR;
          bitcnt_d = 3'd7;
        end
        S_WR_X: begin
          wr_en    = 1'b1;
          state_d  = S_DONE;
          bitcnt_d = 3'd7;
        end
        S_DONE: begin
          if (bitcnt_q == 3'd0) begin
            state_d = S_IGNORE;
            err_d   = 1'b1;
          end else begin
            bitcnt_d = bitcnt_q - 3'd1;
          end
        end
        S_RD: begin
          if (bitcnt_q == 3'd0) begin
            state_d = S_RD_NA;
          end else begin
            bitcnt_d = bitcnt_q - 3'd1;
          end
        end
        S_RD_NA: begin
          state_d  = S_DONE;
          bitcnt_d = 3'd7;
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      // SIO_D only ever changes here, while SCL is low.
      case (state_q)
        S_ID_X:          oe_d = ack_drive & ((shift_q == DEVICE_ID) ||
                                             (shift_q == READ_ID));
        S_SUB_X, S_WR_X: oe_d = ack_drive;
        S_RD:            oe_d = ~bank_q[ptr_q][bitcnt_q];
        default:         oe_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q    <= S_IDLE;
      bitcnt_q   <= 3'd7;
      shift_q    <= 8'h00;
      ptr_q      <= 8'h00;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= 8'h00;
      wr_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      wr_valid_q <= wr_en;
      if (wr_en) begin
        wr_addr_q <= ptr_q;
        wr_data_q <= shift_q;
      end
    end
  end

  // Register bank. The debug port reads the pre-write value in the commit
  // cycle and the new value one cycle later.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int i = 0; i < 256; i++) bank_q[i] <= 8'h00;
      dbg_data_q <= 8'h00;
    end else begin
      if (wr_en) bank_q[ptr_q] <= shift_q;
      dbg_data_q <= bank_q[dbg_addr];
    end
  end

  assign sio_d_oe  = oe_q;
  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign proto_err = err_q;
  assign dbg_data  = dbg_data_q;

endmodule
